// File: rtl/multichannel_pixel_frequency_manager.sv
// rtl/multichannel_pixel_frequency_manager.sv - per-channel pixel sampler and analyzer result dump sequencer
module multichannel_pixel_frequency_manager #(
  parameter int CHANNELS            = 3,
  parameter int DATA_WIDTH          = 8,
  parameter int INDEX_WIDTH         = 11,
  parameter int RESULTS_PER_CHANNEL = 2,
  parameter int HOLD_CYCLES         = 4,
  parameter int REG_WRITE_OP        = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [DATA_WIDTH-1:0]                  pixel_data,
  input  logic                                   pixel_valid,
  input  logic                                   line_start,
  input  logic [DATA_WIDTH-1:0]                  threshold,
  input  logic [CHANNELS*INDEX_WIDTH-1:0]        pixel_index,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   clear_results,
  input  logic [CHANNELS*RESULTS_PER_CHANNEL*32-1:0] result_values,
  output logic [CHANNELS-1:0]                    sample_bits,
  output logic                                   enable,
  output logic                                   analyzer_clear,
  output logic [1:0]                             register_operation,
  output logic [7:0]                             register_number,
  output logic [31:0]                            register_write,
  output logic                                   irq
);

  localparam int NREG = CHANNELS * RESULTS_PER_CHANNEL;
  localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             state;
  logic                   start_prev;
  logic                   stop_prev;
  logic                   start_rise;
  logic                   stop_rise;
  logic [INDEX_WIDTH-1:0] line_count;
  logic                   line_over;
  logic [INDEX_WIDTH-1:0] cur_index;
  logic                   index_ok;
  logic [CHANNELS-1:0]    sample_q;
  logic [HW-1:0]          hold_count;
  logic [31:0]            next_word;

  // Registered rising-edge detection of the start/stop levels
  always_ff @(posedge clock) begin
    if (reset) begin
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
      start_rise <= 1'b0;
      stop_rise  <= 1'b0;
    end else begin
      start_prev <= start;
      stop_prev  <= stop;
      start_rise <= start & ~start_prev;
      stop_rise  <= stop & ~stop_prev;
    end
  end

  // Index of the pixel presented this cycle; once the saturated count has been
  // consumed by one pixel, later pixels of the line carry no valid index
  always_comb begin
    cur_index = line_start ? '0 : line_count;
    index_ok  = line_start | ~line_over;
  end

  // Per-line pixel counter, saturating, running in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      line_count <= '0;
      line_over  <= 1'b0;
    end else if (pixel_valid) begin
      if (line_start) begin
        line_count <= INDEX_WIDTH'(1);
        line_over  <= 1'b0;
      end else if (line_count == {INDEX_WIDTH{1'b1}}) begin
        line_over  <= 1'b1;
      end else begin
        line_count <= line_count + 1'b1;
      end
    end
  end

  // Threshold sampling of each channel's pixel position while running
  always_ff @(posedge clock) begin
    if (reset || state != S_RUN) begin
      sample_q <= '0;
    end else if (pixel_valid && index_ok) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cur_index == pixel_index[c*INDEX_WIDTH +: INDEX_WIDTH])
          sample_q[c] <= (pixel_data > threshold);
      end
    end
  end

  // Result word following the one currently being written
  always_comb begin
    next_word = result_values[32*int'(register_number) +: 32];
  end

  // Run control and sequential register dump
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= S_IDLE;
      analyzer_clear     <= 1'b0;
      register_operation <= 2'd0;
      register_number    <= 8'd0;
      register_write     <= 32'd0;
      hold_count         <= '0;
    end else begin
      analyzer_clear <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_rise && !stop_rise) begin
            state          <= S_RUN;
            analyzer_clear <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop_rise) begin
            state              <= S_DUMP;
            register_operation <= 2'(REG_WRITE_OP);
            register_number    <= 8'd1;
            register_write     <= result_values[31:0];
            hold_count         <= '0;
          end
        end
        S_DUMP: begin
          if (clear_results) begin
            state              <= S_IDLE;
            register_operation <= 2'd0;
            register_number    <= 8'd0;
            register_write     <= 32'd0;
            hold_count         <= '0;
          end else if (hold_count == HW'(HOLD_CYCLES - 1)) begin
            hold_count <= '0;
            if (register_number == 8'(NREG)) begin
              state              <= S_DONE;
              register_operation <= 2'd0;
              register_number    <= 8'd0;
              register_write     <= 32'd0;
            end else begin
              register_number <= register_number + 8'd1;
              register_write  <= next_word;
            end
          end else begin
            hold_count <= hold_count + 1'b1;
          end
        end
        S_DONE: begin
          if (clear_results || start_rise)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign enable      = (state == S_RUN);
  assign irq         = (state == S_DONE);
  assign sample_bits = enable ? sample_q : '0;

endmodule

// File: doc/multichannel_pixel_frequency_manager.md
Name: multichannel_pixel_frequency_manager

Overview:
- Parametrised successor of the three-pixel frequency manager.
- Samples CHANNELS configurable pixel positions per video line against a runtime threshold, producing one binary sample stream per channel for the downstream frequency_analyzer instances.
- After a stop event, sequentially writes all analyzer results into the AXI register file via the register_operation/register_number/register_write interface, then raises irq.
- Single clock domain: pixel stream is pre-synchronised and qualified by pixel_valid.

Parameters:
- CHANNELS, 3, number of sampled pixel positions / analyzer channels (1..16)
- DATA_WIDTH, 8, pixel data width
- INDEX_WIDTH, 11, pixel index / per-line counter width
- RESULTS_PER_CHANNEL, 2, 32-bit result words per channel
- HOLD_CYCLES, 4, cycles each register write is held stable (>=1)
- REG_WRITE_OP, 2, register_operation code for a write

Ports:
- clock  in  1  system (AXI) clock
- reset  in  1  synchronous, active-high reset
- pixel_data  in  DATA_WIDTH  pixel value
- pixel_valid  in  1  pixel_data valid this cycle
- line_start  in  1  first pixel of a line (qualified by pixel_valid)
- threshold  in  DATA_WIDTH  sample is 1 when pixel_data > threshold
- pixel_index  in  CHANNELS*INDEX_WIDTH  sampled pixel index per channel; channel c at bits [c*INDEX_WIDTH +: INDEX_WIDTH]
- start  in  1  level; rising edge begins a run
- stop  in  1  level; rising edge ends run and begins dump
- clear_results  in  1  level; aborts dump or acknowledges DONE
- result_values  in  CHANNELS*RESULTS_PER_CHANNEL*32  analyzer results; word k at [k*32 +: 32]
- sample_bits  out  CHANNELS  per-channel sample stream
- enable  out  1  analyzers enabled (high in RUN only)
- analyzer_clear  out  1  one-cycle clear pulse to analyzers
- register_operation  out  2  0 = idle, REG_WRITE_OP = write
- register_number  out  8  1-based register index
- register_write  out  32  register write data
- irq  out  1  dump complete, level

Behaviour:
- Reset: all outputs 0; state IDLE; edge detectors cleared (prev start/stop = 0); line counter 0.
- Edges: start_rise and stop_rise are registered-previous compares; one cycle detection latency.
- States: IDLE, RUN, DUMP, DONE.
  - IDLE: stop_rise -> stay. start_rise (without stop_rise) -> RUN; analyzer_clear = 1 for exactly that transition cycle.
  - RUN: enable = 1. stop_rise -> DUMP with reg index 1, hold count 0. start_rise ignored.
  - DUMP: NREG = CHANNELS*RESULTS_PER_CHANNEL.
    - For index i in 1..NREG, drive register_operation = REG_WRITE_OP, register_number = i, register_write = result word i-1 (captured at entry of word i).
    - Each word is held HOLD_CYCLES cycles, then i increments.
    - After word NREG's hold: -> DONE, operation/number/write = 0.
    - clear_results -> IDLE immediately; outputs 0; no irq.
    - start/stop edges are ignored.
  - DONE: irq = 1. clear_results or start_rise -> IDLE (irq drops next cycle). start_rise does not directly start a run; a second edge is needed.
- Line counter:
  - pixel_valid && line_start sets counter to 1 and treats the current pixel as index 0.
  - Otherwise pixel_valid increments the counter, saturating at 2^INDEX_WIDTH-1 (no wrap).
  - Counter runs in all states.
- Sampling (RUN only):
  - When pixel_valid and current index == channel index, sample_bits[c] <= (pixel_data > threshold), unsigned compare.
  - Register holds value until the next match. Latency 1 cycle.
  - Outside RUN, sample_bits = 0.
  - Index >= line length means the channel never updates.
- Reset mid-dump/mid-run returns to IDLE with all outputs 0 next cycle.
- Total dump length = NREG*HOLD_CYCLES cycles from DUMP entry; irq asserts on the following cycle.

Test Plan:
- Reset then start pulse -> analyzer_clear high exactly 1 cycle, 2 cycles after start rises; enable = 1; irq = 0.
- CHANNELS=3, indices 63/511/1023, threshold 0x1C, line where pixel 63 = 0x1D, 511 = 0x1C, 1023 = 0xFF -> sample_bits = 3'b101 after pixel 1023 + 1 cycle.
- Run with result_values words = 100..105, stop rise -> register_number 1..6, each held 4 cycles, values 100..105, op = 2; irq high at cycle 25 after DUMP entry; op returns to 0.
- clear_results asserted during word 3 of dump -> IDLE next cycle, op/number = 0, irq never set.
- Start and stop rising the same cycle in IDLE -> remains IDLE, enable = 0; reset asserted mid-dump -> all outputs 0 the next cycle.
- Line of 3000 pixels with INDEX_WIDTH=11 and index 2047 -> single sample at pixel 2047; counter saturates with no further matches until line_start.
